// File: rtl/note_envelope.sv
// note_envelope: ADSR-style (attack/sustain/release) amplitude envelope that PWM-modulates a square-wave tone.
// Envelope steps advance on a free-running prescaler tick; key changes act immediately.
module note_envelope #(
  parameter int ENV_STEP_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tone,
  input  logic       key_on,
  input  logic [3:0] attack_inc,
  input  logic [3:0] release_dec,
  input  logic [7:0] sustain_level,
  output logic       pwm_out,
  output logic [7:0] amp,
  output logic [1:0] state
);
  localparam int PW = $clog2(ENV_STEP_CYCLES);
  localparam logic [PW-1:0] LAST = PW'(ENV_STEP_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} st_t;
  st_t st;
  logic [PW-1:0] presc;
  logic [7:0] pwm_cnt, up, down;
  logic [3:0] inc, dec;
  logic [8:0] sum;
  logic step_tick;
  assign step_tick = presc == LAST;
  assign inc = attack_inc == 4'd0 ? 4'd1 : attack_inc;
  assign dec = release_dec == 4'd0 ? 4'd1 : release_dec;
  // Nine-bit sum so a near-full amp cannot wrap before clamping to sustain
  assign sum = {1'b0, amp} + {5'd0, inc};
  assign up = sum > {1'b0, sustain_level} ? sustain_level : sum[7:0];
  assign down = amp > {4'd0, dec} ? amp - {4'd0, dec} : 8'd0;
  assign state = st;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      pwm_cnt <= 8'd0;
      pwm_out <= 1'b0;
    end else begin
      presc <= step_tick ? '0 : presc + 1'b1;
      pwm_cnt <= pwm_cnt + 8'd1;
      pwm_out <= tone & (pwm_cnt < amp);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      amp <= 8'd0;
    end else begin
      case (st)
        IDLE: begin
          amp <= 8'd0;
          if (key_on) st <= ATTACK;
        end
        ATTACK: begin
          if (!key_on) st <= RELEASE;
          else if (amp >= sustain_level) begin
            amp <= sustain_level;
            st <= SUSTAIN;
          end else if (step_tick) amp <= up;
        end
        SUSTAIN: begin
          if (!key_on) st <= RELEASE;
          else amp <= sustain_level;
        end
        RELEASE: begin
          if (key_on) st <= ATTACK;
          else if (amp == 8'd0) st <= IDLE;
          else if (step_tick) amp <= down;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_note_envelope.sv
// tb_note_envelope: directed envelope scenarios plus random stimulus, all checked cycle by cycle
// against a behavioural model of the envelope rules, prescaler phase and PWM counter.
module tb_note_envelope;
  logic clk = 1'b0, rst_n = 1'b0, tone = 1'b0, key_on = 1'b0;
  logic [3:0] attack_inc = 4'd0, release_dec = 4'd0;
  logic [7:0] sustain_level = 8'd0;
  logic pwm_out;
  logic [7:0] amp;
  logic [1:0] state;
  int total = 0, bad = 0;
  int m_state, m_amp, m_pwm, m_cyc, m_pc;

  note_envelope #(.ENV_STEP_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .tone(tone), .key_on(key_on),
    .attack_inc(attack_inc), .release_dec(release_dec),
    .sustain_level(sustain_level), .pwm_out(pwm_out), .amp(amp), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_amp = 0; m_pwm = 0; m_cyc = 0; m_pc = 0;
  endtask

  // One clock: advance the model using the inputs held before the edge, then compare
  task automatic step();
    int ai, rd, sus, ns, na;
    bit tick;
    @(posedge clk);
    tick = (m_cyc == 3);
    ai = (attack_inc == 0) ? 1 : int'(attack_inc);
    rd = (release_dec == 0) ? 1 : int'(release_dec);
    sus = int'(sustain_level);
    ns = m_state; na = m_amp;
    case (m_state)
      0: begin na = 0; if (key_on) ns = 1; end
      1: if (!key_on) ns = 3;
         else if (m_amp >= sus) begin na = sus; ns = 2; end
         else if (tick) na = (m_amp + ai < sus) ? m_amp + ai : sus;
      2: if (!key_on) ns = 3; else na = sus;
      default: if (key_on) ns = 1;
         else if (m_amp == 0) ns = 0;
         else if (tick) na = (m_amp - rd > 0) ? m_amp - rd : 0;
    endcase
    m_pwm = (tone && m_pc < m_amp) ? 1 : 0;
    m_state = ns; m_amp = na;
    m_cyc = (m_cyc + 1) % 4;
    m_pc = (m_pc + 1) % 256;
    #1;
    chk("state", int'(state), m_state);
    chk("amp", int'(amp), m_amp);
    chk("pwm", int'(pwm_out), m_pwm);
  endtask

  initial begin
    int ones, a;
    #2;
    chk("rst_state", int'(state), 0);
    chk("rst_amp", int'(amp), 0);
    chk("rst_pwm", int'(pwm_out), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    // attack 0,4,8,12,16 then sustain
    tone = 1'b1; key_on = 1'b1; attack_inc = 4'd4; sustain_level = 8'd16; release_dec = 4'd4;
    for (int i = 0; i < 60 && m_state != 2; i++) step();
    chk("att_sus_state", int'(state), 2);
    chk("att_sus_amp", int'(amp), 16);
    // PWM duty at amp=64
    sustain_level = 8'd64;
    repeat (3) step();
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      ones += int'(pwm_out);
    end
    chk("duty64", ones, 64);
    tone = 1'b0;
    step();
    chk("tone0", int'(pwm_out), 0);
    step();
    chk("tone0_hold", int'(pwm_out), 0);
    // retrigger during release at amp 6
    tone = 1'b1; sustain_level = 8'd10;
    step();
    key_on = 1'b0;
    for (int i = 0; i < 60 && !(m_state == 3 && m_amp == 6); i++) step();
    key_on = 1'b1; sustain_level = 8'd16;
    step();
    chk("retrig_state", int'(state), 1);
    chk("retrig_amp", int'(amp), 6);
    for (int i = 0; i < 10 && m_amp == 6; i++) step();
    chk("retrig_next", int'(amp), 10);
    // release saturation from sustain amp 10
    for (int i = 0; i < 60 && m_state != 2; i++) step();
    sustain_level = 8'd10;
    step();
    chk("rel_start_amp", int'(amp), 10);
    key_on = 1'b0;
    for (int i = 0; i < 60 && m_state != 0; i++) step();
    chk("rel_idle_state", int'(state), 0);
    chk("rel_idle_amp", int'(amp), 0);
    // attack_inc=0 counts as 1
    attack_inc = 4'd0; sustain_level = 8'd3; key_on = 1'b1;
    for (int i = 0; i < 60 && m_state != 2; i++) step();
    chk("inc0_amp", int'(amp), 3);
    key_on = 1'b0; release_dec = 4'd0;
    for (int i = 0; i < 60 && m_state != 0; i++) step();
    // sustain 0 goes straight to SUSTAIN at amp 0
    sustain_level = 8'd0; key_on = 1'b1;
    step();
    step();
    step();
    chk("sus0_state", int'(state), 2);
    chk("sus0_amp", int'(amp), 0);
    // key release coincident with a tick leaves amp untouched
    key_on = 1'b0;
    for (int i = 0; i < 60 && m_state != 0; i++) step();
    attack_inc = 4'd2; sustain_level = 8'd200; key_on = 1'b1;
    for (int i = 0; i < 60 && !(m_state == 1 && m_cyc == 3 && m_amp > 0); i++) step();
    a = m_amp;
    key_on = 1'b0;
    step();
    chk("coinc_state", int'(state), 3);
    chk("coinc_amp", int'(amp), a);
    // reset mid-attack at amp 12 with key held
    release_dec = 4'd15;
    for (int i = 0; i < 60 && m_state != 0; i++) step();
    attack_inc = 4'd4; key_on = 1'b1;
    for (int i = 0; i < 60 && !(m_state == 1 && m_amp == 12); i++) step();
    chk("pre_rst_amp", int'(amp), 12);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", int'(state), 0);
    chk("arst_amp", int'(amp), 0);
    chk("arst_pwm", int'(pwm_out), 0);
    model_reset();
    #3 rst_n = 1'b1;
    step();
    chk("post_rst_state", int'(state), 1);
    // random stimulus
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(39) == 0) key_on = ~key_on;
      tone = ($urandom_range(7) != 0);
      if ($urandom_range(99) == 0) begin
        attack_inc = 4'($urandom);
        release_dec = 4'($urandom);
        sustain_level = ($urandom_range(3) == 0) ? 8'($urandom_range(255, 240)) : 8'($urandom);
      end
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
